// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch queue.
// Queue entries carry an instruction word and the PC it was fetched from.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          FQ_XLEN   = 32;

    typedef struct packed {
        logic [31:0]        instr;
        logic [FQ_XLEN-1:0] pc;
    } fq_entry_t;

    // Counter width that can hold the values 0..depth inclusive.
    function automatic int fq_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fq_storage.sv
// Entry array for the fetch queue.
// It has one write port and one asynchronous read port. The data is not reset.
module fq_storage #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [W-1:0]             i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [W-1:0]             o_rd_data
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: it owns the fetch PC and buffers fetched words in a FIFO for Decode.
// Optional macro FETCH_QUEUE_BYPASS_EN lets an empty queue present the imem word to Decode in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [31:0]            imem_rdata,
    input  logic                   take_d,
    output logic                   valid_d,
    output logic [31:0]            instr_d,
    output logic [XLEN-1:0]        pc_d,
    output logic [XLEN-1:0]        pcplus4_d,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW      = $clog2(DEPTH);
    localparam int CW      = fq_cnt_w(DEPTH);
    localparam int ENTRY_W = $bits(fq_entry_t) - FQ_XLEN + XLEN;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0]    r_fpc;
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic [ENTRY_W-1:0] w_rd_data;
    logic [31:0]        w_q_instr;
    logic [XLEN-1:0]    w_q_pc;
    logic               w_byp;
    logic               w_head_valid;
    logic [31:0]        w_head_instr;
    logic [XLEN-1:0]    w_head_pc;
    logic               w_push;
    logic               w_pop;
    logic               w_byp_take;
    logic               w_wr_en;
    logic               w_rd_adv;

    fq_storage #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_storage (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data ({imem_rdata, r_fpc}),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    assign w_q_instr = w_rd_data[ENTRY_W-1 -: 32];
    assign w_q_pc    = w_rd_data[XLEN-1:0];

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_byp        = (r_count == '0) && !redirect;
    assign w_head_valid = (r_count != '0) || w_byp;
    assign w_head_instr = w_byp ? imem_rdata : w_q_instr;
    assign w_head_pc    = w_byp ? r_fpc : w_q_pc;
`else
    assign w_byp        = 1'b0;
    assign w_head_valid = (r_count != '0);
    assign w_head_instr = w_q_instr;
    assign w_head_pc    = w_q_pc;
`endif

    assign w_pop      = take_d && w_head_valid && !redirect;
    assign w_push     = !redirect && ((r_count < FULL) || w_pop);
    // A bypassed word consumed in the same cycle it is fetched never touches the array.
    assign w_byp_take = w_byp && w_pop;
    assign w_wr_en    = w_push && !w_byp_take;
    assign w_rd_adv   = w_pop && !w_byp_take;

    assign valid_d   = w_head_valid;
    assign instr_d   = w_head_valid ? w_head_instr : NOP_INSTR;
    assign pc_d      = w_head_valid ? w_head_pc : '0;
    assign pcplus4_d = w_head_valid ? (w_head_pc + XLEN'(4)) : '0;
    assign imem_addr = r_fpc;
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fpc    <= RESET_PC;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_fpc    <= redirect_pc;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push) begin
                r_fpc <= r_fpc + XLEN'(4);
            end
            r_count <= r_count + CW'(w_wr_en) - CW'(w_rd_adv);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, directed corner cases,
// and a randomized run compared against a queue-based reference model.
module tb_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        take_d;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic [2:0]  count;

    int n_pass  = 0;
    int n_total = 0;

    fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .take_d      (take_d),
        .valid_d     (valid_d),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pcplus4_d   (pcplus4_d),
        .count       (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    assign imem_rdata = tag(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        take;
        int          exp_cnt;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic redir, input logic [31:0] rpc,
                                input logic take, input int c, input logic v,
                                input logic [31:0] p, input logic [31:0] a);
        vec_t r;
        r.rst = rst; r.redir = redir; r.rpc = rpc; r.take = take;
        r.exp_cnt = c; r.exp_valid = v; r.exp_pc = p; r.exp_addr = a;
        return r;
    endfunction

    // The reference model is a queue of fetched PCs plus a fetch PC.
    logic [31:0] mq[$];
    logic [31:0] mfpc;

    task automatic check_post(input string tagn, input int c, input logic v,
                              input logic [31:0] p, input logic [31:0] a);
        chk({tagn, ".count"}, 32'(count), 32'(c));
        chk({tagn, ".valid"}, 32'(valid_d), 32'(v));
        chk({tagn, ".pc"}, pc_d, v ? p : 32'h0);
        chk({tagn, ".pc4"}, pcplus4_d, v ? p + 32'd4 : 32'h0);
        chk({tagn, ".instr"}, instr_d, v ? tag(p) : NOP);
        chk({tagn, ".addr"}, imem_addr, a);
    endtask

    initial begin
        logic        byp, ev, pop, push;
        logic [31:0] epc;
        int          tp;

        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; take_d = 1'b0;

        // Directed stimulus: each row's expectations describe the state after the row's clock edge.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(0, 0, 0, 0, i, 1, 32'h0, 32'(4 * i)));
        tbl.push_back(mk(0, 0, 0, 0, 4, 1, 32'h0, 32'h10));
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(0, 0, 0, 1, 4, 1, 32'(4 * k), 32'(32'h10 + 4 * k)));
        tbl.push_back(mk(0, 1, 32'h100, 1, 0, 0, 0, 32'h100));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'h100, 32'h104));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'h104, 32'h108));
        tbl.push_back(mk(0, 0, 0, 0, 2, 1, 32'h104, 32'h10C));
        tbl.push_back(mk(0, 0, 0, 0, 3, 1, 32'h104, 32'h110));
        tbl.push_back(mk(0, 0, 0, 0, 4, 1, 32'h104, 32'h114));
        tbl.push_back(mk(0, 1, 32'h202, 1, 0, 0, 0, 32'h202));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h202, 32'h206));
        tbl.push_back(mk(0, 0, 0, 0, 2, 1, 32'h202, 32'h20A));
        tbl.push_back(mk(0, 0, 0, 0, 3, 1, 32'h202, 32'h20E));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, RESET_PC));
        tbl.push_back(mk(1, 1, 32'h300, 0, 0, 0, 0, RESET_PC));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'h0, 32'h4));
        tbl.push_back(mk(0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0, 32'hFFFF_FFF8));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC));
        tbl.push_back(mk(0, 0, 0, 0, 2, 1, 32'hFFFF_FFF8, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 1, 32'hFFFF_FFFC, 32'h4));

`ifndef FETCH_QUEUE_BYPASS_EN
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset = tbl[i].rst; redirect = tbl[i].redir;
            redirect_pc = tbl[i].rpc; take_d = tbl[i].take;
            @(posedge clk); #1;
            check_post($sformatf("vec%0d", i), tbl[i].exp_cnt, tbl[i].exp_valid,
                       tbl[i].exp_pc, tbl[i].exp_addr);
        end
`else
        // With the bypass, an empty queue hands the fetched word straight to Decode.
        @(negedge clk); reset = 1'b1; redirect = 1'b0; take_d = 1'b0;
        @(negedge clk); reset = 1'b0; take_d = 1'b1; #1;
        chk("byp.valid", 32'(valid_d), 32'h1);
        chk("byp.pc", pc_d, RESET_PC);
        chk("byp.instr", instr_d, tag(RESET_PC));
        @(posedge clk); #1;
        chk("byp.count", 32'(count), 32'h0);
        chk("byp.pc_next", pc_d, RESET_PC + 32'd4);
        chk("byp.addr", imem_addr, RESET_PC + 32'd4);
`endif

        // Random stimulus: outputs are compared just before each edge, then the model advances.
        mq.delete();
        mfpc = RESET_PC;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            tp = ((i / 100) % 3 == 0) ? 20 : (((i / 100) % 3 == 1) ? 85 : 55);
            reset       = (i == 0) || ($urandom_range(0, 99) < 2);
            redirect    = ($urandom_range(0, 99) < 7);
            redirect_pc = $urandom;
            take_d      = ($urandom_range(0, 99) < tp);
            #1;
            byp = BYP && (mq.size() == 0) && !redirect;
            ev  = (mq.size() > 0) || byp;
            epc = (mq.size() > 0) ? mq[0] : mfpc;
            if (i > 0) check_post($sformatf("rnd%0d", i), mq.size(), ev, epc, mfpc);
            @(posedge clk);
            if (reset) begin
                mq.delete(); mfpc = RESET_PC;
            end else if (redirect) begin
                mq.delete(); mfpc = redirect_pc;
            end else begin
                pop  = take_d && ev;
                push = (mq.size() < DEPTH) || pop;
                if (byp && pop) begin
                    mfpc = mfpc + 32'd4;
                end else begin
                    if (pop) void'(mq.pop_front());
                    if (push) begin
                        mq.push_back(mfpc);
                        mfpc = mfpc + 32'd4;
                    end
                end
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
